// File: rtl/bus_pack_fifo.sv
// 64-bit word in, 128-bit beat out FIFO. A message ending on an even slot is padded with
// PAD_WORD so every message occupies whole beats; beats are always read from even slots.
module bus_pack_fifo #(
    parameter int unsigned DEPTH    = 32,
    parameter logic [63:0] PAD_WORD = 64'h0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     write_en_i,
    input  logic [63:0]              write_data_i,
    input  logic                     write_last_i,
    input  logic                     read_en_i,
    output logic [127:0]             read_data_o,
    output logic                     read_valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     fifo_full_o,
    output logic                     fifo_half_full_o,
    output logic                     fifo_empty_o,
    output logic                     beat_avail_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [63:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [127:0]   read_data_q;
    logic           read_valid_q;
    logic           overflow_q;
    logic           underflow_q;

    logic           wr_acc;
    logic           wr_pad;
    logic [1:0]     wr_inc;
    logic           rd_do;
    logic [AW-1:0]  wr_pad_idx;
    logic [AW-1:0]  rd_hi_idx;

    assign fifo_full_o      = (count_q == CW'(DEPTH));
    assign fifo_half_full_o = (count_q >= CW'(DEPTH / 2));
    assign fifo_empty_o     = (count_q == '0);
    assign beat_avail_o     = (count_q >= CW'(2));

    assign count_o      = count_q;
    assign read_data_o  = read_data_q;
    assign read_valid_o = read_valid_q;
    assign overflow_o   = overflow_q;
    assign underflow_o  = underflow_q;

    // Both pointers are even whenever they are used as a pair base, so the partner slot is ptr|1.
    assign wr_pad_idx = {wr_ptr_q[AW-1:1], 1'b1};
    assign rd_hi_idx  = {rd_ptr_q[AW-1:1], 1'b1};

    always_comb begin
        wr_acc   = write_en_i & ~fifo_full_o;
        // Pointer parity equals count parity, so an even pointer guarantees room for the pad.
        wr_pad   = wr_acc & write_last_i & ~wr_ptr_q[0];
        wr_inc   = {wr_pad, wr_acc & ~wr_pad};
        rd_do    = read_en_i & beat_avail_o;
        count_d  = count_q + CW'(wr_inc) - (rd_do ? CW'(2) : '0);
        wr_ptr_d = wr_ptr_q + AW'(wr_inc);
        rd_ptr_d = rd_ptr_q + (rd_do ? AW'(2) : '0);
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= write_data_i;
        end
        if (wr_pad) begin
            mem_q[wr_pad_idx] <= PAD_WORD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            read_valid_q <= rd_do;
            if (rd_do) begin
                read_data_q <= {mem_q[rd_hi_idx], mem_q[rd_ptr_q]};
            end
            if (write_en_i && fifo_full_o) begin
                overflow_q <= 1'b1;
            end
            if (read_en_i && !beat_avail_o) begin
                underflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_pack_fifo.sv
// Bench for bus_pack_fifo: directed scenarios plus randomized traffic, all checked against a
// queue-of-words reference model.
module tb_bus_pack_fifo;

    localparam int          DEPTH = 32;
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam logic [63:0] PAD   = 64'hFEED_FACE_CAFE_F00D;

    logic           clk;
    logic           rst_n;
    logic           write_en;
    logic [63:0]    write_data;
    logic           write_last;
    logic           read_en;
    logic [127:0]   read_data;
    logic           read_valid;
    logic [CW-1:0]  count;
    logic           fifo_full;
    logic           fifo_half_full;
    logic           fifo_empty;
    logic           beat_avail;
    logic           overflow;
    logic           underflow;

    bus_pack_fifo #(
        .DEPTH    (DEPTH),
        .PAD_WORD (PAD)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .write_en_i       (write_en),
        .write_data_i     (write_data),
        .write_last_i     (write_last),
        .read_en_i        (read_en),
        .read_data_o      (read_data),
        .read_valid_o     (read_valid),
        .count_o          (count),
        .fifo_full_o      (fifo_full),
        .fifo_half_full_o (fifo_half_full),
        .fifo_empty_o     (fifo_empty),
        .beat_avail_o     (beat_avail),
        .overflow_o       (overflow),
        .underflow_o      (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: stored words in arrival order plus expected registered outputs.
    logic [63:0]  mq [$];
    logic [127:0] exp_rd;
    logic         exp_rv;
    logic         exp_ovf;
    logic         exp_udf;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        check("count",      128'(count),          128'(unsigned'(n)));
        check("full",       128'(fifo_full),      128'(n == DEPTH));
        check("half_full",  128'(fifo_half_full), 128'(n >= DEPTH / 2));
        check("empty",      128'(fifo_empty),     128'(n == 0));
        check("beat_avail", 128'(beat_avail),     128'(n >= 2));
        check("overflow",   128'(overflow),       128'(exp_ovf));
        check("underflow",  128'(underflow),      128'(exp_udf));
        check("read_valid", 128'(read_valid),     128'(exp_rv));
        check("read_data",  read_data,            exp_rd);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // One clock: decisions use the pre-edge occupancy, reads take the two oldest words.
    task automatic cycle(input logic we, input logic [63:0] wd, input logic wl, input logic re);
        int pre;
        logic [63:0] lo, hi;
        write_en   = we;
        write_data = wd;
        write_last = wl;
        read_en    = re;
        pre    = mq.size();
        exp_rv = 1'b0;
        if (re) begin
            if (pre >= 2) begin
                lo     = mq.pop_front();
                hi     = mq.pop_front();
                exp_rd = {hi, lo};
                exp_rv = 1'b1;
            end else begin
                exp_udf = 1'b1;
            end
        end
        if (we) begin
            if (pre == DEPTH) begin
                exp_ovf = 1'b1;
            end else begin
                mq.push_back(wd);
                if (wl && (pre % 2 == 0)) mq.push_back(PAD);
            end
        end
        @(posedge clk);
        #1;
        write_en   = 1'b0;
        write_last = 1'b0;
        read_en    = 1'b0;
        check_all();
    endtask

    task automatic model_reset();
        mq.delete();
        exp_rd  = '0;
        exp_rv  = 1'b0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drain();
        while (mq.size() >= 2) cycle(1'b0, '0, 1'b0, 1'b1);
        if (mq.size() == 1) begin
            cycle(1'b1, rnd64(), 1'b0, 1'b0);
            cycle(1'b0, '0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        write_en   = 1'b0;
        write_data = '0;
        write_last = 1'b0;
        read_en    = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Sustained write every cycle, read every other cycle, over several pointer wraps.
        cycle(1'b1, rnd64(), 1'b0, 1'b0);
        cycle(1'b1, rnd64(), 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, rnd64(), 1'b0, (i % 2) == 0);
            check("sustain_bound", 128'(count <= CW'(2)), 128'(1));
        end
        check("sustain_no_ovf", 128'(overflow), 128'(0));
        check("sustain_no_udf", 128'(underflow), 128'(0));
        drain();

        // Two words form one beat, older word in the low half.
        cycle(1'b1, 64'hA, 1'b0, 1'b0);
        cycle(1'b1, 64'hB, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("ab_beat", read_data, {64'hB, 64'hA});
        check("ab_empty", 128'(fifo_empty), 128'(1));

        // Odd-length message gets padded.
        cycle(1'b1, 64'h1, 1'b0, 1'b0);
        cycle(1'b1, 64'h2, 1'b0, 1'b0);
        cycle(1'b1, 64'h3, 1'b1, 1'b0);
        check("pad_count", 128'(count), 128'(4));
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("pad_beat0", read_data, {64'h2, 64'h1});
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("pad_beat1", read_data, {PAD, 64'h3});

        // Even-length message with write_last is not padded.
        cycle(1'b1, 64'h4, 1'b0, 1'b0);
        cycle(1'b1, 64'h5, 1'b1, 1'b0);
        check("nopad_count", 128'(count), 128'(2));
        drain();

        // Read with a single word stored.
        cycle(1'b1, 64'h7, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("udf_rv", 128'(read_valid), 128'(0));
        check("udf_flag", 128'(underflow), 128'(1));
        check("udf_count", 128'(count), 128'(1));
        drain();

        // Fill, overflow, then simultaneous dropped write and performed read.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, rnd64(), 1'b0, 1'b0);
        check("fill_full", 128'(fifo_full), 128'(1));
        cycle(1'b1, rnd64(), 1'b0, 1'b0);
        check("ovf_flag", 128'(overflow), 128'(1));
        check("ovf_count", 128'(count), 128'(DEPTH));
        cycle(1'b1, rnd64(), 1'b0, 1'b1);
        check("ovf_rd_count", 128'(count), 128'(DEPTH - 2));
        drain();

        // Randomized traffic: a filling phase then a draining phase.
        for (int i = 0; i < 3000; i++) begin
            logic we, wl, re;
            if (i < 1500) begin
                we = ($urandom_range(0, 99) < 75);
                re = ($urandom_range(0, 99) < 30);
            end else begin
                we = ($urandom_range(0, 99) < 40);
                re = ($urandom_range(0, 99) < 50);
            end
            wl = ($urandom_range(0, 99) < 20);
            cycle(we, rnd64(), wl, re);
        end
        drain();

        // Asynchronous reset mid-stream with a read pending; sticky flags are set here.
        for (int i = 0; i < 10; i++) cycle(1'b1, rnd64(), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("pre_rst_rv", 128'(read_valid), 128'(1));
        read_en = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_rv", 128'(read_valid), 128'(0));
        check("rst_rd", read_data, 128'(0));
        check("rst_count", 128'(count), 128'(0));
        check("rst_ovf", 128'(overflow), 128'(0));
        check("rst_udf", 128'(underflow), 128'(0));
        check_all();
        @(posedge clk);
        #3;
        read_en = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_empty", 128'(fifo_empty), 128'(1));
        check_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
